// File: rtl/key_pkg.sv
// Shared constants and types for the key event arbiter.
package key_pkg;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    // Wide enough for the largest supported key count (16).
    localparam int KEY_IDX_W = 4;

    typedef struct packed {
        logic [KEY_IDX_W-1:0] key;
        logic                 press;
    } key_event_t;

    typedef enum logic {
        EV_EMPTY = 1'b0,
        EV_FULL  = 1'b1
    } ev_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request after last_grant, wrapping.
module rr_arbiter #(
    parameter int N_KEYS = 4
) (
    input  logic [N_KEYS-1:0]         req,
    input  logic [$clog2(N_KEYS)-1:0] last_grant,
    output logic [N_KEYS-1:0]         grant,
    output logic [$clog2(N_KEYS)-1:0] grant_idx,
    output logic                      any_req
);

    localparam int IDX_W = $clog2(N_KEYS);

    // Walk from farthest to nearest so the nearest requester is the last one written.
    always_comb begin : search
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        idx       = 0;
        for (int k = N_KEYS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % N_KEYS;
            if (req[idx]) begin
                grant     = N_KEYS'(1) << idx;
                grant_idx = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Buffers per-key debounced events in one-deep slots and serializes them round-robin
// onto a single valid/ready port, reporting any event that finds its slot occupied.
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int N_KEYS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_KEYS-1:0]         key_flag,
    input  logic [N_KEYS-1:0]         key_state,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [$clog2(N_KEYS)-1:0] ev_key,
    output logic                      ev_press,
    output logic                      drop_flag,
    output logic [$clog2(N_KEYS)-1:0] drop_key
);

    localparam int IDX_W = $clog2(N_KEYS);

    logic [N_KEYS-1:0] pend;
    logic [N_KEYS-1:0] pend_press;
    logic [N_KEYS-1:0] grant;
    logic [N_KEYS-1:0] drained;
    logic [N_KEYS-1:0] drop_vec;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  drop_idx;
    logic              any_req;
    logic              load_en;
    ev_state_t         state;
    key_event_t        next_ev;

    rr_arbiter #(.N_KEYS(N_KEYS)) u_arb (
        .req        (pend),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_req    (any_req)
    );

    // The output register accepts a new event when empty or being accepted this edge.
    assign load_en  = any_req && (state == EV_EMPTY || ev_ready);
    assign drained  = load_en ? grant : '0;
    assign drop_vec = key_flag & pend & ~drained;

    always_comb begin
        next_ev       = '0;
        next_ev.key   = KEY_IDX_W'(grant_idx);
        next_ev.press = pend_press[grant_idx];
        drop_idx      = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (drop_vec[i]) drop_idx = IDX_W'(i);
        end
    end

    // A slot being drained this edge can take a new event without losing anything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= '0;
            pend_press <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (key_flag[i] && (!pend[i] || drained[i])) begin
                    pend[i]       <= 1'b1;
                    pend_press[i] <= (key_state[i] == KEY_PRESSED);
                end else if (drained[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EV_EMPTY;
            ev_valid   <= 1'b0;
            ev_key     <= '0;
            ev_press   <= 1'b0;
            last_grant <= IDX_W'(N_KEYS - 1);
        end else begin
            case (state)
                EV_EMPTY: begin
                    if (load_en) begin
                        state      <= EV_FULL;
                        ev_valid   <= 1'b1;
                        ev_key     <= next_ev.key[IDX_W-1:0];
                        ev_press   <= next_ev.press;
                        last_grant <= grant_idx;
                    end
                end
                EV_FULL: begin
                    if (load_en) begin
                        ev_key     <= next_ev.key[IDX_W-1:0];
                        ev_press   <= next_ev.press;
                        last_grant <= grant_idx;
                    end else if (ev_ready) begin
                        state    <= EV_EMPTY;
                        ev_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= EV_EMPTY;
                    ev_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_flag <= 1'b0;
            drop_key  <= '0;
        end else begin
            drop_flag <= |drop_vec;
            if (|drop_vec) drop_key <= drop_idx;
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter: directed key events, queued expectations, negedge monitor.
module tb_key_event_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    typedef struct packed {
        logic [W-1:0] key;
        logic         press;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] key_flag;
    logic [N-1:0] key_state;
    logic         ev_valid;
    logic         ev_ready;
    logic [W-1:0] ev_key;
    logic         ev_press;
    logic         drop_flag;
    logic [W-1:0] drop_key;

    exp_t         exp_q[$];
    logic [W-1:0] drop_q[$];
    int           n_compared = 0;
    int           n_mismatched = 0;

    key_event_arbiter #(.N_KEYS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_flag  (key_flag),
        .key_state (key_state),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_key    (ev_key),
        .ev_press  (ev_press),
        .drop_flag (drop_flag),
        .drop_key  (drop_key)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] flags, input logic [N-1:0] states);
        key_flag  = flags;
        key_state = states;
        @(posedge clk);
        #1;
        key_flag  = '0;
        key_state = '1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushEvent(input int k, input logic p);
        exp_t e;
        e.key   = W'(k);
        e.press = p;
        exp_q.push_back(e);
    endtask

    // Monitor: every handshake and every drop pulse must match the head of its queue.
    always @(negedge clk) begin : monitor
        exp_t         e;
        logic [W-1:0] dk;
        if (!rst && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_event: got key %0d press %0d, expected none", ev_key, ev_press);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_ev_key", 32'(ev_key), 32'(e.key));
                checkOutput("sb_ev_press", 32'(ev_press), 32'(e.press));
            end
        end
        if (!rst && drop_flag) begin
            if (drop_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_drop: got drop_key %0d, expected no drop", drop_key);
            end else begin
                dk = drop_q.pop_front();
                checkOutput("sb_drop_key", 32'(drop_key), 32'(dk));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst       = 1'b1;
        ev_ready  = 1'b1;
        key_flag  = '0;
        key_state = '1;
        #12;
        checkOutput("rst_ev_valid", 32'(ev_valid), 32'd0);
        checkOutput("rst_ev_key", 32'(ev_key), 32'd0);
        checkOutput("rst_ev_press", 32'(ev_press), 32'd0);
        checkOutput("rst_drop_flag", 32'(drop_flag), 32'd0);
        checkOutput("rst_drop_key", 32'(drop_key), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        $display("[TB] single press on key 2");
        pushEvent(2, 1'b1);
        applyStimulus(4'b0100, 4'b1011);
        checkOutput("single_not_yet", 32'(ev_valid), 32'd0);
        idle(1);
        checkOutput("single_valid", 32'(ev_valid), 32'd1);
        checkOutput("single_key", 32'(ev_key), 32'd2);
        checkOutput("single_press", 32'(ev_press), 32'd1);
        idle(1);
        checkOutput("single_one_cycle", 32'(ev_valid), 32'd0);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] simultaneous events on keys 0, 1, 3");
        pushEvent(0, 1'b1);
        pushEvent(1, 1'b0);
        pushEvent(3, 1'b1);
        applyStimulus(4'b1011, 4'b0110);
        idle(1);
        checkOutput("sim_first", 32'({ev_valid, ev_key}), 32'({1'b1, 2'd0}));
        idle(1);
        checkOutput("sim_second", 32'({ev_valid, ev_key}), 32'({1'b1, 2'd1}));
        idle(1);
        checkOutput("sim_third", 32'({ev_valid, ev_key}), 32'({1'b1, 2'd3}));
        idle(1);
        checkOutput("sim_done", 32'(ev_valid), 32'd0);

        $display("[TB] backpressure on key 2 release");
        ev_ready = 1'b0;
        pushEvent(2, 1'b0);
        applyStimulus(4'b0100, 4'b1111);
        idle(1);
        for (int c = 0; c < 10; c++) begin
            checkOutput("bp_hold", 32'({ev_valid, ev_key, ev_press}), 32'({1'b1, 2'd2, 1'b0}));
            idle(1);
        end
        ev_ready = 1'b1;
        idle(1);
        checkOutput("bp_accepted", 32'(ev_valid), 32'd0);

        $display("[TB] drop on key 1 behind stalled output");
        ev_ready = 1'b0;
        pushEvent(3, 1'b1);
        applyStimulus(4'b1000, 4'b0111);
        idle(1);
        pushEvent(1, 1'b1);
        applyStimulus(4'b0010, 4'b1101);
        idle(2);
        drop_q.push_back(2'd1);
        applyStimulus(4'b0010, 4'b1111);
        checkOutput("drop_pulse", 32'({drop_flag, drop_key}), 32'({1'b1, 2'd1}));
        idle(1);
        checkOutput("drop_once", 32'(drop_flag), 32'd0);
        checkOutput("drop_key_held", 32'(drop_key), 32'd1);
        ev_ready = 1'b1;
        idle(1);
        checkOutput("drop_next_loaded", 32'({ev_valid, ev_key, ev_press}), 32'({1'b1, 2'd1, 1'b1}));
        idle(1);
        checkOutput("drop_drained", 32'(ev_valid), 32'd0);

        $display("[TB] capture on drain of key 0");
        pushEvent(0, 1'b1);
        pushEvent(0, 1'b0);
        applyStimulus(4'b0001, 4'b1110);
        applyStimulus(4'b0001, 4'b1111);
        checkOutput("cod_first", 32'({ev_valid, ev_key, ev_press}), 32'({1'b1, 2'd0, 1'b1}));
        checkOutput("cod_no_drop", 32'(drop_flag), 32'd0);
        idle(1);
        checkOutput("cod_second", 32'({ev_valid, ev_key, ev_press}), 32'({1'b1, 2'd0, 1'b0}));
        idle(1);
        checkOutput("cod_done", 32'(ev_valid), 32'd0);

        $display("[TB] reset with events in flight");
        ev_ready = 1'b0;
        applyStimulus(4'b1111, 4'b0000);
        idle(1);
        checkOutput("mid_valid_before", 32'(ev_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_ev_valid", 32'(ev_valid), 32'd0);
        checkOutput("mid_ev_key", 32'(ev_key), 32'd0);
        checkOutput("mid_ev_press", 32'(ev_press), 32'd0);
        checkOutput("mid_drop_flag", 32'(drop_flag), 32'd0);
        checkOutput("mid_drop_key", 32'(drop_key), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ev_ready = 1'b1;
        idle(3);
        checkOutput("mid_no_stale", 32'(ev_valid), 32'd0);
        pushEvent(0, 1'b1);
        pushEvent(3, 1'b0);
        applyStimulus(4'b1001, 4'b1110);
        idle(1);
        checkOutput("mid_first_key0", 32'({ev_valid, ev_key}), 32'({1'b1, 2'd0}));
        idle(1);
        checkOutput("mid_then_key3", 32'({ev_valid, ev_key}), 32'({1'b1, 2'd3}));
        idle(3);

        checkOutput("events_all_seen", 32'(exp_q.size()), 32'd0);
        checkOutput("drops_all_seen", 32'(drop_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/key_event_arbiter.md
# key_event_arbiter

Collects debounced press/release events from `N_KEYS` key debounce instances and serializes them onto one valid/ready event port, using round-robin arbitration. It sits between the per-key debouncers (single-cycle `key_flag` pulse plus level `key_state`, 0 = pressed) and the single consumer of key events, such as a UI or LED controller. Each key has a one-deep pending slot, so events that arrive together are not lost. An event that cannot be buffered is reported, not silently discarded.

## Interface
- `N_KEYS`, default 4: number of debounced key inputs (2..16).
- `IDX_W`, derived localparam, `$clog2(N_KEYS)`: key index width.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_flag`  in  N_KEYS  per-key 1-cycle event strobe from the debouncer.
- `key_state`  in  N_KEYS  per-key debounced level; 0 = pressed, 1 = released. Sampled when `key_flag[i]`=1.
- `ev_valid`  out  1  event available.
- `ev_ready`  in  1  consumer accepts the event when `ev_valid && ev_ready` at a rising edge.
- `ev_key`  out  IDX_W  index of the key that produced the event.
- `ev_press`  out  1  1 = press (`key_state` was 0), 0 = release.
- `drop_flag`  out  1  1-cycle pulse: an incoming event was discarded.
- `drop_key`  out  IDX_W  index of the discarded event; valid while `drop_flag`=1 and held until the next drop.

## Operation
- **Per-key slot.** Each key `i` has `pend[i]` and `pend_press[i]`.
- **Capture.** `key_flag[i]`=1 and the slot is free, or the slot is being drained in the same cycle: set `pend[i]`=1 and `pend_press[i]`=`~key_state[i]`.
- **Drop.** `key_flag[i]`=1 while `pend[i]`=1 and the slot is not drained that cycle:
  - keep the older event and discard the new one;
  - `drop_flag`=1 next cycle, `drop_key`=i;
  - if several keys drop in one cycle, report the lowest index.
- **Output register FSM, 2 states.**
  - EMPTY (`ev_valid`=0): if any `pend` is set, grant one key, load `ev_key`/`ev_press`, clear that `pend`, then go to FULL.
  - FULL (`ev_valid`=1): hold `ev_key`/`ev_press` stable until accepted.
    - Acceptance with another `pend` set: load the next granted key in the same edge and stay in FULL.
    - Acceptance with no `pend` set: go to EMPTY.
- **Round-robin.** Search starts at `last_grant+1`, wraps modulo `N_KEYS`, and takes the first key with `pend` set. `last_grant` updates on every load.
- **Fairness.** A key whose slot is continuously pending is granted within `N_KEYS` loads.
- **Pending visibility.** A `pend` bit set in cycle t is eligible for grant from cycle t+1. There is no combinational bypass from `key_flag` to the output.

## Timing
- **Reset values.** `ev_valid`=0, `ev_key`=0, `ev_press`=0, `drop_flag`=0, `drop_key`=0, all `pend`=0, `last_grant`=N_KEYS-1 (so key 0 has first priority).
- **Latency.** A `key_flag` sampled at edge E gives `ev_valid`=1 after edge E+1, with the output empty and no competing pending key.
- **Throughput.** One event per cycle while `ev_ready`=1 and slots are pending.
- **Outputs.** All outputs are registered. `ev_ready` has no combinational path to any output.
- **Reset mid-operation.** Outputs go to reset values immediately. Pending and in-flight events are lost, with no `drop_flag`.
- **Simultaneous capture and drain of the same slot.** The old event is loaded to the output and the new event is captured. No drop.

## Structure
- **Package `key_pkg`:**
  - `KEY_PRESSED`/`KEY_RELEASED` level constants (0/1);
  - typedef `key_event_t` {key index, press bit};
  - FSM state enum {`EV_EMPTY`, `EV_FULL`}.
- **Sub-module `rr_arbiter`:**
  - parameterized on `N_KEYS`;
  - inputs: request vector, last_grant;
  - outputs: one-hot grant, grant index, any_req;
  - purely combinational.
- **Top level:** slots, output register, FSM and drop logic.

## Test plan
- **Single press:** `key_flag[2]`=1 with `key_state[2]`=0, `ev_ready`=1 → `ev_valid`=1 two edges later with `ev_key`=2, `ev_press`=1, high for exactly 1 cycle.
- **Simultaneous events:** flags on keys 0, 1 and 3 in one cycle, `ev_ready`=1 → events for keys 0, 1, 3 on consecutive cycles, with no gaps and no drops.
- **Backpressure:** event pending with `ev_ready`=0 for 10 cycles → `ev_valid`, `ev_key` and `ev_press` stable for all 10 cycles; accepted on the first `ev_ready`=1 edge.
- **Drop:**
  - key 1 press flag, then a key 1 release flag 3 cycles later, while key 1 is still pending behind a stalled output → `drop_flag` pulses once with `drop_key`=1;
  - only key 1's press is delivered.
- **Capture on drain:** a key 0 flag in the same cycle its pending slot is loaded to the output → no drop, and both key 0 events are delivered in order.
- **Reset mid-operation:** assert `rst` with 3 keys pending and `ev_valid`=1 → all outputs 0 immediately. After release, there are no stale events and the next event's grant starts from key 0.
